// File: rtl/lsq_ooo_if.sv
// Bundles the dispatch, AGU, memory-request, forwarding, retire and status signals of lsq_ooo.
// Latency: wires only, no storage.
// Backpressure: master drives requests and mem_req_ready; slave answers with disp_ready and mem_req_valid.
interface lsq_ooo_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int CNT_W = 5
);
    logic             disp_valid;
    logic             disp_is_store;
    logic [TAG_W-1:0] disp_tag;
    logic [XLEN-1:0]  disp_data;
    logic             disp_ready;
    logic             agu_valid;
    logic [TAG_W-1:0] agu_tag;
    logic [XLEN-1:0]  agu_addr;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_req_store;
    logic [XLEN-1:0]  mem_req_addr;
    logic [XLEN-1:0]  mem_req_data;
    logic [TAG_W-1:0] mem_req_tag;
    logic             fwd_valid;
    logic [TAG_W-1:0] fwd_tag;
    logic [XLEN-1:0]  fwd_data;
    logic             ret_valid;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    // Core side: dispatch, AGU, retire and memory accept.
    modport master (
        output disp_valid, disp_is_store, disp_tag, disp_data,
        output agu_valid, agu_tag, agu_addr,
        output mem_req_ready, ret_valid,
        input  disp_ready, mem_req_valid, mem_req_store, mem_req_addr,
        input  mem_req_data, mem_req_tag, fwd_valid, fwd_tag, fwd_data,
        input  count, full, empty
    );

    // Queue side.
    modport slave (
        input  disp_valid, disp_is_store, disp_tag, disp_data,
        input  agu_valid, agu_tag, agu_addr,
        input  mem_req_ready, ret_valid,
        output disp_ready, mem_req_valid, mem_req_store, mem_req_addr,
        output mem_req_data, mem_req_tag, fwd_valid, fwd_tag, fwd_data,
        output count, full, empty
    );
endinterface

// File: rtl/lsq_ooo.sv
// Circular load-store queue: in-order allocate/retire, store-to-load forwarding, one memory request per cycle.
// Latency: forward and memory request both appear one cycle after the entry becomes eligible.
// Backpressure: disp_ready = !full; mem_req_* hold stable while mem_req_ready is low.
module lsq_ooo #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rstn,
    lsq_ooo_if.slave   lsq
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] r_valid, r_is_store, r_addr_valid, r_issued, r_done;
    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic [XLEN-1:0]  r_addr [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_mem_valid, r_mem_store;
    logic [XLEN-1:0]  r_mem_addr, r_mem_data;
    logic [TAG_W-1:0] r_mem_tag;
    logic [PTR_W-1:0] r_mem_idx;
    logic             r_fwd_valid;
    logic [TAG_W-1:0] r_fwd_tag;
    logic [XLEN-1:0]  r_fwd_data;

    logic             w_full, w_empty, w_disp, w_ret, w_mem_load;
    logic             w_fwd_found, w_mem_found;
    logic [PTR_W-1:0] w_fwd_idx, w_fwd_src, w_mem_idx;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_disp     = lsq.disp_valid && !w_full;
    assign w_ret      = lsq.ret_valid && !w_empty && r_valid[r_head] && r_done[r_head];
    assign w_mem_load = !r_mem_valid || lsq.mem_req_ready;

    // Scan entries oldest-first: pick the oldest forwardable load and the oldest memory candidate.
    always_comb begin : sel
        logic             blk;
        logic             hit;
        logic [PTR_W-1:0] src;
        logic [PTR_W-1:0] li;
        logic [PTR_W-1:0] si;
        w_fwd_found = 1'b0;
        w_fwd_idx   = '0;
        w_fwd_src   = '0;
        w_mem_found = 1'b0;
        w_mem_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            li  = r_head + PTR_W'(k);
            blk = 1'b0;
            hit = 1'b0;
            src = '0;
            // Older stores: unknown address blocks; later (younger) matches overwrite earlier ones.
            for (int j = 0; j < DEPTH; j++) begin
                si = r_head + PTR_W'(j);
                if (j < k && r_valid[si] && r_is_store[si]) begin
                    if (!r_addr_valid[si]) begin
                        blk = 1'b1;
                    end else if (r_addr[si] == r_addr[li]) begin
                        hit = 1'b1;
                        src = si;
                    end
                end
            end
            if (r_valid[li] && r_addr_valid[li] && !r_issued[li]) begin
                if (r_is_store[li]) begin
                    // Stores only go to memory from the head, keeping commits in order.
                    if (k == 0) begin
                        w_mem_found = 1'b1;
                        w_mem_idx   = li;
                    end
                end else if (!blk) begin
                    if (hit) begin
                        if (!w_fwd_found) begin
                            w_fwd_found = 1'b1;
                            w_fwd_idx   = li;
                            w_fwd_src   = src;
                        end
                    end else if (!w_mem_found) begin
                        w_mem_found = 1'b1;
                        w_mem_idx   = li;
                    end
                end
            end
        end
    end

    // Entry state, pointers and occupancy; dispatch is applied last so it overrides stale marks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid      <= '0;
            r_is_store   <= '0;
            r_addr_valid <= '0;
            r_issued     <= '0;
            r_done       <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i]  <= '0;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lsq.agu_valid && r_valid[i] && r_tag[i] == lsq.agu_tag) begin
                    r_addr[i]       <= lsq.agu_addr;
                    r_addr_valid[i] <= 1'b1;
                end
            end
            if (w_mem_load && w_mem_found) r_issued[w_mem_idx] <= 1'b1;
            if (w_fwd_found) begin
                r_issued[w_fwd_idx] <= 1'b1;
                r_done[w_fwd_idx]   <= 1'b1;
            end
            if (r_mem_valid && lsq.mem_req_ready) r_done[r_mem_idx] <= 1'b1;
            if (w_ret) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_disp) begin
                r_valid[r_tail]      <= 1'b1;
                r_is_store[r_tail]   <= lsq.disp_is_store;
                r_tag[r_tail]        <= lsq.disp_tag;
                r_data[r_tail]       <= lsq.disp_data;
                r_addr_valid[r_tail] <= 1'b0;
                r_issued[r_tail]     <= 1'b0;
                r_done[r_tail]       <= 1'b0;
                r_tail               <= r_tail + 1'b1;
            end
            if (w_disp && !w_ret)      r_count <= r_count + 1'b1;
            else if (!w_disp && w_ret) r_count <= r_count - 1'b1;
        end
    end

    // Registered memory request and forward pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_valid <= 1'b0;
            r_mem_store <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_tag   <= '0;
            r_mem_idx   <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_tag   <= '0;
            r_fwd_data  <= '0;
        end else begin
            if (w_mem_load) begin
                r_mem_valid <= w_mem_found;
                if (w_mem_found) begin
                    r_mem_store <= r_is_store[w_mem_idx];
                    r_mem_addr  <= r_addr[w_mem_idx];
                    r_mem_data  <= r_is_store[w_mem_idx] ? r_data[w_mem_idx] : '0;
                    r_mem_tag   <= r_tag[w_mem_idx];
                    r_mem_idx   <= w_mem_idx;
                end
            end
            r_fwd_valid <= w_fwd_found;
            if (w_fwd_found) begin
                r_fwd_tag  <= r_tag[w_fwd_idx];
                r_fwd_data <= r_data[w_fwd_src];
            end
        end
    end

    assign lsq.disp_ready    = !w_full;
    assign lsq.mem_req_valid = r_mem_valid;
    assign lsq.mem_req_store = r_mem_store;
    assign lsq.mem_req_addr  = r_mem_addr;
    assign lsq.mem_req_data  = r_mem_data;
    assign lsq.mem_req_tag   = r_mem_tag;
    assign lsq.fwd_valid     = r_fwd_valid;
    assign lsq.fwd_tag       = r_fwd_tag;
    assign lsq.fwd_data      = r_fwd_data;
    assign lsq.count         = r_count;
    assign lsq.full          = w_full;
    assign lsq.empty         = w_empty;
endmodule

// File: tb/tb_lsq_ooo.sv
// Directed bench for lsq_ooo: vector table for forwarding/blocking, hand sequences for fill, stall, wrap, reset.
module tb_lsq_ooo;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;
    int   sb_q[$];
    logic sb_en = 1'b0;
    int   n_acc = 0;

    always #5 clk = ~clk;

    lsq_ooo_if #(.XLEN(32), .TAG_W(6), .CNT_W(5)) bus ();
    lsq_ooo #(.DEPTH(16), .XLEN(32), .TAG_W(6), .CNT_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .lsq  (bus)
    );

    typedef struct {
        logic [31:0] dv, ds, dtag, ddat;
        logic [31:0] av, atag, aaddr;
        logic [31:0] rv, mr;
        logic [31:0] cnt, mv, mtag, mst, maddr, mdat;
        logic [31:0] fv, ftag, fdat;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        bus.disp_valid    = 1'b0;
        bus.disp_is_store = 1'b0;
        bus.disp_tag      = '0;
        bus.disp_data     = '0;
        bus.agu_valid     = 1'b0;
        bus.agu_tag       = '0;
        bus.agu_addr      = '0;
        bus.ret_valid     = 1'b0;
    endtask

    // One clock edge; records an accepted request against the expected issue order.
    task automatic tick();
        logic       acc;
        logic [5:0] acc_tag;
        acc     = sb_en && bus.mem_req_valid && bus.mem_req_ready;
        acc_tag = bus.mem_req_tag;
        @(posedge clk);
        #1;
        if (acc) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL issue_extra: got tag %0d, expected no request", acc_tag);
            end else begin
                chk("issue_order", 32'(acc_tag), 32'(sb_q.pop_front()));
                n_acc++;
            end
        end
    endtask

    task automatic do_reset();
        clr();
        bus.mem_req_ready = 1'b1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic st, input int tag, input logic [31:0] data);
        clr();
        bus.disp_valid    = 1'b1;
        bus.disp_is_store = st;
        bus.disp_tag      = 6'(tag);
        bus.disp_data     = data;
        tick();
        clr();
    endtask

    task automatic agu(input int tag, input logic [31:0] addr);
        clr();
        bus.agu_valid = 1'b1;
        bus.agu_tag   = 6'(tag);
        bus.agu_addr  = addr;
        tick();
        clr();
    endtask

    task automatic ret();
        clr();
        bus.ret_valid = 1'b1;
        tick();
        clr();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq;
        //          dv ds dtag ddat          av atag aaddr  rv mr cnt mv mtag mst maddr  mdat          fv ftag fdat
        tbl[0]  = '{1, 1, 1, 'hDEADBEEF,     0, 0, 0,       0, 1, 1,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[1]  = '{1, 0, 2, 0,              0, 0, 0,       0, 1, 2,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0,              1, 1, 'h100,   0, 1, 2,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0,              1, 2, 'h100,   0, 1, 2,  1, 1, 1, 'h100,  'hDEADBEEF,   0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,              0, 0, 0,       0, 1, 2,  0, 0, 0, 0,      0,            1, 2, 'hDEADBEEF};
        tbl[5]  = '{0, 0, 0, 0,              0, 0, 0,       0, 1, 2,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0,              0, 0, 0,       1, 1, 1,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0,              0, 0, 0,       1, 1, 0,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[8]  = '{1, 1, 3, 'h33,           0, 0, 0,       0, 1, 1,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[9]  = '{1, 0, 4, 0,              0, 0, 0,       0, 1, 2,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[10] = '{0, 0, 0, 0,              1, 4, 'h200,   0, 1, 2,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[11] = '{0, 0, 0, 0,              0, 0, 0,       0, 1, 2,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[12] = '{0, 0, 0, 0,              1, 3, 'h300,   0, 1, 2,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[13] = '{0, 0, 0, 0,              0, 0, 0,       0, 1, 2,  1, 3, 1, 'h300,  'h33,         0, 0, 0};
        tbl[14] = '{0, 0, 0, 0,              0, 0, 0,       0, 1, 2,  1, 4, 0, 'h200,  0,            0, 0, 0};
        tbl[15] = '{0, 0, 0, 0,              0, 0, 0,       0, 1, 2,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[16] = '{0, 0, 0, 0,              0, 0, 0,       1, 1, 1,  0, 0, 0, 0,      0,            0, 0, 0};
        tbl[17] = '{0, 0, 0, 0,              0, 0, 0,       1, 1, 0,  0, 0, 0, 0,      0,            0, 0, 0};

        // Reset state.
        clr();
        bus.mem_req_ready = 1'b1;
        #2;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_disp_ready", 32'(bus.disp_ready), 1);
        chk("rst_mem_valid", 32'(bus.mem_req_valid), 0);
        chk("rst_fwd_valid", 32'(bus.fwd_valid), 0);
        chk("rst_mem_addr", bus.mem_req_addr, 0);
        chk("rst_fwd_tag", 32'(bus.fwd_tag), 0);
        do_reset();

        // Fill with address-less loads, then an ignored 17th dispatch.
        for (int i = 0; i < 16; i++) begin
            disp(1'b0, i, 32'h0);
            chk($sformatf("fill_count_%0d", i), 32'(bus.count), 32'(i + 1));
        end
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_disp_ready", 32'(bus.disp_ready), 0);
        disp(1'b0, 16, 32'h0);
        chk("overfill_count", 32'(bus.count), 16);
        chk("overfill_mem_valid", 32'(bus.mem_req_valid), 0);

        // Forwarding and blocked-load vectors.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            bus.disp_valid    = tbl[i].dv[0];
            bus.disp_is_store = tbl[i].ds[0];
            bus.disp_tag      = tbl[i].dtag[5:0];
            bus.disp_data     = tbl[i].ddat;
            bus.agu_valid     = tbl[i].av[0];
            bus.agu_tag       = tbl[i].atag[5:0];
            bus.agu_addr      = tbl[i].aaddr;
            bus.ret_valid     = tbl[i].rv[0];
            bus.mem_req_ready = tbl[i].mr[0];
            tick();
            clr();
            chk($sformatf("v%0d_count", i), 32'(bus.count), tbl[i].cnt);
            chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("v%0d_mem_valid", i), 32'(bus.mem_req_valid), tbl[i].mv);
            chk($sformatf("v%0d_fwd_valid", i), 32'(bus.fwd_valid), tbl[i].fv);
            if (tbl[i].mv[0]) begin
                chk($sformatf("v%0d_mem_tag", i), 32'(bus.mem_req_tag), tbl[i].mtag);
                chk($sformatf("v%0d_mem_store", i), 32'(bus.mem_req_store), tbl[i].mst);
                chk($sformatf("v%0d_mem_addr", i), bus.mem_req_addr, tbl[i].maddr);
                chk($sformatf("v%0d_mem_data", i), bus.mem_req_data, tbl[i].mdat);
            end
            if (tbl[i].fv[0]) begin
                chk($sformatf("v%0d_fwd_tag", i), 32'(bus.fwd_tag), tbl[i].ftag);
                chk($sformatf("v%0d_fwd_data", i), bus.fwd_data, tbl[i].fdat);
            end
        end

        // Stalled store request holds stable, then one accept and a retire.
        do_reset();
        bus.mem_req_ready = 1'b0;
        disp(1'b1, 5, 32'h55);
        chk("stall_count", 32'(bus.count), 1);
        agu(5, 32'h40);
        chk("stall_pre_valid", 32'(bus.mem_req_valid), 0);
        tick();
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("stall%0d_valid", c), 32'(bus.mem_req_valid), 1);
            chk($sformatf("stall%0d_tag", c), 32'(bus.mem_req_tag), 5);
            chk($sformatf("stall%0d_store", c), 32'(bus.mem_req_store), 1);
            chk($sformatf("stall%0d_addr", c), bus.mem_req_addr, 32'h40);
            chk($sformatf("stall%0d_data", c), bus.mem_req_data, 32'h55);
            if (c < 5) tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();
        chk("stall_accepted_valid", 32'(bus.mem_req_valid), 0);
        bus.mem_req_ready = 1'b0;
        ret();
        chk("stall_ret_count", 32'(bus.count), 0);

        // Wrap: keep the queue cycling so both pointers pass the end several times.
        do_reset();
        sb_en = 1'b1;
        for (int i = 0; i < 16; i++) disp(1'b0, i, 32'h0);
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(i);
            agu(i, 32'h1000 + 32'(i * 4));
        end
        repeat (4) tick();
        chk("wrap_fill_count", 32'(bus.count), 16);
        seq = 16;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) ret();
            chk($sformatf("wrap%0d_after_ret", r), 32'(bus.count), 12);
            for (int k = 0; k < 4; k++) disp(1'b0, seq + k, 32'h0);
            chk($sformatf("wrap%0d_refill", r), 32'(bus.count), 16);
            chk($sformatf("wrap%0d_full", r), 32'(bus.full), 1);
            for (int k = 0; k < 4; k++) begin
                sb_q.push_back(seq + k);
                agu(seq + k, 32'h2000 + 32'((seq + k) * 4));
            end
            repeat (4) tick();
            chk($sformatf("wrap%0d_bound", r), 32'(bus.count <= 5'd16), 1);
            seq += 4;
        end
        for (int k = 0; k < 16; k++) ret();
        chk("wrap_drain_count", 32'(bus.count), 0);
        chk("wrap_drain_empty", 32'(bus.empty), 1);
        chk("wrap_accepts", 32'(n_acc), 36);
        chk("wrap_sb_left", 32'(sb_q.size()), 0);
        sb_en = 1'b0;

        // Asynchronous reset while a request is pending.
        do_reset();
        bus.mem_req_ready = 1'b0;
        disp(1'b1, 7, 32'h77);
        agu(7, 32'h80);
        tick();
        chk("areset_pre_valid", 32'(bus.mem_req_valid), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("areset_mem_valid", 32'(bus.mem_req_valid), 0);
        chk("areset_count", 32'(bus.count), 0);
        chk("areset_empty", 32'(bus.empty), 1);
        chk("areset_mem_tag", 32'(bus.mem_req_tag), 0);
        #2;
        rstn = 1'b1;
        bus.mem_req_ready = 1'b1;
        tick();
        tick();
        chk("areset_after_valid", 32'(bus.mem_req_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
